// File: rtl/fetch_pkg.sv
// Shared types and constants for the pre-fetch PC generator and its request queue.
package fetch_pkg;

   localparam int MAX_FW = 4;

   localparam logic [4:0] NO_EX            = 5'h00;
   localparam logic [4:0] EXC_ITLB_REFILL  = 5'h02;
   localparam logic [4:0] EXC_ITLB_INVALID = 5'h03;
   localparam logic [4:0] EXC_ADEL         = 5'h04;

   localparam logic [31:0] RESET_VEC   = 32'hBFC0_0000;
   localparam logic [31:0] REFILL_VEC  = 32'hBFC0_0200;
   localparam logic [31:0] GENERAL_VEC = 32'hBFC0_0380;

   typedef struct packed {
      logic [31:0]       pc;
      logic [MAX_FW-1:0] mask;
      logic              ex;
      logic [4:0]        exctype;
      logic [1:0]        epoch;
   } fetch_entry_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_req_fifo.sv
// Shift-register request queue toward the ICache; entry 0 is always the registered head.
module fetch_req_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   fetch_entry_t  ent_q [DEPTH];
   fetch_entry_t  ent_d [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d, wr_idx_s;
   logic          do_pop_s, do_push_s;

   assign empty_o   = (cnt_q == {CW{1'b0}});
   assign full_o    = (cnt_q == FULL_CNT);
   assign head_o    = ent_q[0];
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   // Vacated slots shift in zeros so an empty queue presents an all-zero head.
   always_comb begin
      ent_d    = ent_q;
      cnt_d    = cnt_q;
      wr_idx_s = cnt_q;
      if (flush_i) begin
         cnt_d = {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      end else begin
         if (do_pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i + 1];
            ent_d[DEPTH - 1] = '0;
            wr_idx_s         = cnt_q - ONE_CNT;
         end else begin
            wr_idx_s = cnt_q;
         end
         if (do_push_s) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = (wr_idx_s == CW'(i)) ? data_i : ent_d[i];
            cnt_d = do_pop_s ? cnt_q : cnt_q + ONE_CNT;
         end else begin
            cnt_d = do_pop_s ? cnt_q - ONE_CNT : cnt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         ent_q <= ent_d;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Pre-fetch PC generator: builds fetch groups, applies redirect priority and
// delay-slot-aware prediction, and tags every group with the current epoch.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int          FETCH_WIDTH = 2,
   parameter int          QDEPTH      = 4,
   parameter logic [31:0] RESET_PC    = RESET_VEC,
   parameter logic [31:0] REFILL_PC   = REFILL_VEC,
   parameter logic [31:0] GENERAL_PC  = GENERAL_VEC
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   eret_valid_i,
   input  logic [31:0]            eret_pc_i,
   input  logic                   flush_i,
   input  logic                   flush_refill_i,
   input  logic                   br_redirect_i,
   input  logic [31:0]            br_target_i,
   input  logic                   bpu_valid_i,
   input  logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] bpu_slot_i,
   input  logic [31:0]            bpu_target_i,
   input  logic                   itlb_refill_i,
   input  logic                   itlb_invalid_i,
   output logic                   req_valid_o,
   input  logic                   req_ready_i,
   output logic [31:0]            req_pc_o,
   output logic [FETCH_WIDTH-1:0] req_mask_o,
   output logic                   req_ex_o,
   output logic [4:0]             req_exctype_o,
   output logic [1:0]             req_epoch_o,
   output logic [1:0]             cur_epoch_o,
   output logic [31:0]            redirect_cnt_o,
   output logic [31:0]            mispred_cnt_o
);
   localparam int                     SW          = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [31:0]            GROUP_BYTES = 32'(4 * FETCH_WIDTH);
   localparam logic [FETCH_WIDTH-1:0] FULL_MASK   = {FETCH_WIDTH{1'b1}};
   localparam logic [FETCH_WIDTH-1:0] SLOT0_MASK  = FETCH_WIDTH'(1'b1);
   localparam logic [SW-1:0]          LAST_SLOT   = SW'(FETCH_WIDTH - 1);

   logic [31:0]            pc_q, pc_d, pend_pc_q, pend_pc_d;
   logic                   pend_valid_q, pend_valid_d, halted_q, halted_d;
   logic [1:0]             epoch_q, epoch_d;
   logic [31:0]            redirect_cnt_q, redirect_cnt_d, mispred_cnt_q, mispred_cnt_d;

   logic                   redirect_s, push_s, pop_s, full_s, empty_s, exc_s, unused_mask_s;
   logic [31:0]            redirect_pc_s, seq_pc_s;
   logic [1:0]             off_s;
   logic [2:0]             keep_s;
   logic [4:0]             exctype_s;
   logic [FETCH_WIDTH-1:0] mask_s;
   fetch_entry_t           entry_s, head_s;

   assign redirect_s    = eret_valid_i | flush_i | br_redirect_i;
   assign redirect_pc_s = eret_valid_i ? eret_pc_i :
                          flush_i      ? (flush_refill_i ? REFILL_PC : GENERAL_PC) : br_target_i;
   assign off_s         = 2'(pc_q[31:2] & 30'(FETCH_WIDTH - 1));
   assign seq_pc_s      = (pc_q & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;
   assign keep_s        = 3'(bpu_slot_i) + 3'd2;
   assign pop_s         = ~empty_s & req_ready_i;
   assign push_s        = ~redirect_s & ~halted_q & (~full_s | pop_s);

   // Fetch exception of the current PC, highest priority first.
   always_comb begin
      exc_s     = 1'b1;
      exctype_s = NO_EX;
      if (pc_q[1:0] != 2'b00) begin
         exctype_s = EXC_ADEL;
      end else if (itlb_refill_i) begin
         exctype_s = EXC_ITLB_REFILL;
      end else if (itlb_invalid_i) begin
         exctype_s = EXC_ITLB_INVALID;
      end else begin
         exc_s = 1'b0;
      end
   end

   always_comb begin
      pc_d           = pc_q;
      pend_valid_d   = pend_valid_q;
      pend_pc_d      = pend_pc_q;
      halted_d       = halted_q;
      epoch_d        = epoch_q;
      redirect_cnt_d = redirect_cnt_q;
      mispred_cnt_d  = mispred_cnt_q;
      mask_s         = FULL_MASK << off_s;
      if (redirect_s) begin
         pc_d           = redirect_pc_s;
         pend_valid_d   = 1'b0;
         halted_d       = 1'b0;
         epoch_d        = epoch_q + 2'd1;
         redirect_cnt_d = sat_inc(redirect_cnt_q);
         mispred_cnt_d  = br_redirect_i ? sat_inc(mispred_cnt_q) : mispred_cnt_q;
      end else if (push_s) begin
         if (exc_s) begin
            mask_s   = SLOT0_MASK << off_s;
            halted_d = 1'b1;
         end else if (pend_valid_q) begin
            // Deferred delay slot: only slot 0 of this group, then the predicted target.
            mask_s       = SLOT0_MASK;
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
         end else if (bpu_valid_i) begin
            mask_s = mask_s & ~(FULL_MASK << keep_s);
            if (bpu_slot_i == LAST_SLOT) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = bpu_target_i;
               pc_d         = seq_pc_s;
            end else begin
               pc_d = bpu_target_i;
            end
         end else begin
            pc_d = seq_pc_s;
         end
      end else begin
         pc_d = pc_q;
      end
   end

   always_comb begin
      entry_s         = '0;
      entry_s.pc      = pc_q;
      entry_s.mask    = MAX_FW'(mask_s);
      entry_s.ex      = exc_s;
      entry_s.exctype = exctype_s;
      entry_s.epoch   = epoch_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q           <= RESET_PC;
         pend_valid_q   <= 1'b0;
         pend_pc_q      <= 32'd0;
         halted_q       <= 1'b0;
         epoch_q        <= 2'd0;
         redirect_cnt_q <= 32'd0;
         mispred_cnt_q  <= 32'd0;
      end else begin
         pc_q           <= pc_d;
         pend_valid_q   <= pend_valid_d;
         pend_pc_q      <= pend_pc_d;
         halted_q       <= halted_d;
         epoch_q        <= epoch_d;
         redirect_cnt_q <= redirect_cnt_d;
         mispred_cnt_q  <= mispred_cnt_d;
      end
   end

   fetch_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect_s),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  (entry_s),
      .head_o  (head_s),
      .empty_o (empty_s),
      .full_o  (full_s)
   );

   assign req_valid_o    = ~empty_s;
   assign req_pc_o       = head_s.pc;
   assign req_mask_o     = head_s.mask[FETCH_WIDTH-1:0];
   assign req_ex_o       = head_s.ex;
   assign req_exctype_o  = head_s.exctype;
   assign req_epoch_o    = head_s.epoch;
   assign cur_epoch_o    = epoch_q;
   assign redirect_cnt_o = redirect_cnt_q;
   assign mispred_cnt_o  = mispred_cnt_q;
   assign unused_mask_s  = ^head_s.mask;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, a reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_fetch_pc_gen;
   import fetch_pkg::*;

   localparam int FW = 2;
   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        reset, eret_valid, flush, flush_refill, br_redirect, bpu_valid;
   logic        itlb_refill, itlb_invalid, req_ready;
   logic [31:0] eret_pc, br_target, bpu_target;
   logic [0:0]  bpu_slot;
   logic        req_valid, req_ex;
   logic [31:0] req_pc, redirect_cnt, mispred_cnt;
   logic [FW-1:0] req_mask;
   logic [4:0]  req_exctype;
   logic [1:0]  req_epoch, cur_epoch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_pc_gen #(.FETCH_WIDTH(FW), .QDEPTH(QD)) dut (
      .clk(clk), .reset(reset), .eret_valid_i(eret_valid), .eret_pc_i(eret_pc),
      .flush_i(flush), .flush_refill_i(flush_refill), .br_redirect_i(br_redirect),
      .br_target_i(br_target), .bpu_valid_i(bpu_valid), .bpu_slot_i(bpu_slot),
      .bpu_target_i(bpu_target), .itlb_refill_i(itlb_refill), .itlb_invalid_i(itlb_invalid),
      .req_valid_o(req_valid), .req_ready_i(req_ready), .req_pc_o(req_pc),
      .req_mask_o(req_mask), .req_ex_o(req_ex), .req_exctype_o(req_exctype),
      .req_epoch_o(req_epoch), .cur_epoch_o(cur_epoch),
      .redirect_cnt_o(redirect_cnt), .mispred_cnt_o(mispred_cnt)
   );

   // Reference model: queue of groups plus architectural fetch state.
   typedef struct {
      logic [31:0]   pc;
      logic [FW-1:0] mask;
      logic          ex;
      logic [4:0]    code;
      logic [1:0]    ep;
   } ment_t;

   ment_t       m_q[$];
   logic [31:0] m_pc = RESET_VEC;
   logic [31:0] m_ptgt = 32'd0;
   bit          m_pend = 1'b0;
   bit          m_halt = 1'b0;
   int          m_epoch = 0;
   longint      m_rc = 0;
   longint      m_mc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic model_step();
      ment_t e;
      int    off;
      bit    pop;
      if (reset) begin
         m_q.delete();
         m_pc = RESET_VEC; m_pend = 1'b0; m_halt = 1'b0; m_epoch = 0; m_rc = 0; m_mc = 0;
      end else if (eret_valid || flush || br_redirect) begin
         m_q.delete();
         m_pc    = eret_valid ? eret_pc : flush ? (flush_refill ? REFILL_VEC : GENERAL_VEC) : br_target;
         m_epoch = (m_epoch + 1) % 4;
         m_pend  = 1'b0;
         m_halt  = 1'b0;
         m_rc    = (m_rc < 64'hFFFF_FFFF) ? m_rc + 1 : m_rc;
         if (br_redirect) m_mc = (m_mc < 64'hFFFF_FFFF) ? m_mc + 1 : m_mc;
      end else begin
         pop = (m_q.size() > 0) && req_ready;
         if (!m_halt && (m_q.size() < QD || pop)) begin
            off  = int'((m_pc / 4) % FW);
            e.pc = m_pc; e.ep = 2'(m_epoch); e.ex = 1'b0; e.code = NO_EX; e.mask = '0;
            if (m_pc % 4 != 0 || itlb_refill || itlb_invalid) begin
               e.ex   = 1'b1;
               e.code = (m_pc % 4 != 0) ? EXC_ADEL : itlb_refill ? EXC_ITLB_REFILL : EXC_ITLB_INVALID;
               e.mask[off] = 1'b1;
               m_halt = 1'b1;
            end else if (m_pend) begin
               e.mask[0] = 1'b1;
               m_pc = m_ptgt;
               m_pend = 1'b0;
            end else begin
               for (int s = 0; s < FW; s++)
                  e.mask[s] = (s >= off) && (!bpu_valid || s <= int'(bpu_slot) + 1);
               if (bpu_valid && int'(bpu_slot) < FW - 1) begin
                  m_pc = bpu_target;
               end else begin
                  if (bpu_valid) begin m_pend = 1'b1; m_ptgt = bpu_target; end
                  m_pc = m_pc - (m_pc % (4 * FW)) + 4 * FW;
               end
            end
            if (pop) void'(m_q.pop_front());
            m_q.push_back(e);
         end else if (pop) begin
            void'(m_q.pop_front());
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clr_inputs();
      reset = 1'b0; eret_valid = 1'b0; flush = 1'b0; flush_refill = 1'b0; br_redirect = 1'b0;
      bpu_valid = 1'b0; itlb_refill = 1'b0; itlb_invalid = 1'b0; req_ready = 1'b1;
      eret_pc = 32'd0; br_target = 32'd0; bpu_target = 32'd0; bpu_slot = 1'b0;
   endtask

   task automatic compare_model();
      chk("valid", 32'(req_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("pc", req_pc, m_q[0].pc);
         chk("mask", 32'(req_mask), 32'(m_q[0].mask));
         chk("ex", 32'(req_ex), 32'(m_q[0].ex));
         chk("exctype", 32'(req_exctype), 32'(m_q[0].code));
         chk("req_epoch", 32'(req_epoch), 32'(m_q[0].ep));
      end
      chk("cur_epoch", 32'(cur_epoch), 32'(m_epoch));
      chk("redirect_cnt", redirect_cnt, 32'(m_rc));
      chk("mispred_cnt", mispred_cnt, 32'(m_mc));
   endtask

   typedef struct {
      bit rst, er, fl, flr, br; logic [31:0] ept, tgt;
      bit bpu; logic [0:0] slot; logic [31:0] btgt; bit inv, rdy;
      bit ev; logic [31:0] epc; logic [1:0] emask; bit eex; logic [4:0] ecode; logic [1:0] eep;
   } vec_t;

   function automatic vec_t mk(input bit rst, er, fl, flr, br, input logic [31:0] ept, tgt,
                               input bit bpu, input logic [0:0] slot, input logic [31:0] btgt,
                               input bit inv, rdy, ev, input logic [31:0] epc,
                               input logic [1:0] emask, input bit eex, input logic [4:0] ecode,
                               input logic [1:0] eep);
      vec_t v;
      v.rst = rst; v.er = er; v.fl = fl; v.flr = flr; v.br = br; v.ept = ept; v.tgt = tgt;
      v.bpu = bpu; v.slot = slot; v.btgt = btgt; v.inv = inv; v.rdy = rdy; v.ev = ev;
      v.epc = epc; v.emask = emask; v.eex = eex; v.ecode = ecode; v.eep = eep;
      return v;
   endfunction

   vec_t vt[30];
   int   n;

   initial begin
      //               rst er fl flr br eret_pc       br_target     bpu sl bpu_target    inv rdy  v  pc            mask ex code              ep
      vt[0]  = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd0);
      vt[1]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'hBFC0_0000, 2'd3, 0, NO_EX,            2'd0);
      vt[2]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'hBFC0_0008, 2'd3, 0, NO_EX,            2'd0);
      vt[3]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'hBFC0_0010, 2'd3, 0, NO_EX,            2'd0);
      vt[4]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h8000_0000, 0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd1);
      vt[5]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h8000_1000, 0, 1,   1, 32'h8000_0000, 2'd3, 0, NO_EX,            2'd1);
      vt[6]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_1000, 2'd3, 0, NO_EX,            2'd1);
      vt[7]  = mk(0, 0, 0, 0, 1, 32'h0,         32'h8000_0000, 0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd2);
      vt[8]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 1, 32'h8000_3000, 0, 1,   1, 32'h8000_0000, 2'd3, 0, NO_EX,            2'd2);
      vt[9]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_0008, 2'd1, 0, NO_EX,            2'd2);
      vt[10] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_3000, 2'd3, 0, NO_EX,            2'd2);
      for (int i = 11; i < 15; i++)
         vt[i] = mk(0, 0, 0, 0, 0, 32'h0,       32'h0,         0, 0, 32'h0,         0, 0,   1, 32'h8000_3000, 2'd3, 0, NO_EX,            2'd2);
      vt[15] = mk(0, 0, 0, 0, 1, 32'h0,         32'h8000_2000, 0, 0, 32'h0,         0, 0,   0, 32'h0,         2'd0, 0, NO_EX,            2'd3);
      vt[16] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_2000, 2'd3, 0, NO_EX,            2'd3);
      vt[17] = mk(0, 1, 1, 0, 1, 32'h8000_4000, 32'h8000_5000, 0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd0);
      vt[18] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_4000, 2'd3, 0, NO_EX,            2'd0);
      vt[19] = mk(0, 0, 0, 0, 1, 32'h0,         32'h8000_0002, 0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd1);
      vt[20] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_0002, 2'd1, 1, EXC_ADEL,         2'd1);
      vt[21] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd1);
      vt[22] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd1);
      vt[23] = mk(0, 0, 1, 1, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd2);
      vt[24] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'hBFC0_0200, 2'd3, 0, NO_EX,            2'd2);
      vt[25] = mk(0, 0, 0, 0, 1, 32'h0,         32'h8000_0004, 0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd3);
      vt[26] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_0004, 2'd2, 0, NO_EX,            2'd3);
      vt[27] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_0008, 2'd3, 0, NO_EX,            2'd3);
      vt[28] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1, 1,   1, 32'h8000_0010, 2'd1, 1, EXC_ITLB_INVALID, 2'd3);
      vt[29] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         2'd0, 0, NO_EX,            2'd3);

      clr_inputs();
      for (int i = 0; i < 30; i++) begin
         reset = vt[i].rst; eret_valid = vt[i].er; flush = vt[i].fl; flush_refill = vt[i].flr;
         br_redirect = vt[i].br; eret_pc = vt[i].ept; br_target = vt[i].tgt; bpu_valid = vt[i].bpu;
         bpu_slot = vt[i].slot; bpu_target = vt[i].btgt; itlb_invalid = vt[i].inv; req_ready = vt[i].rdy;
         cycle();
         chk($sformatf("v%0d_valid", i), 32'(req_valid), 32'(vt[i].ev));
         chk($sformatf("v%0d_cur_epoch", i), 32'(cur_epoch), 32'(vt[i].eep));
         if (vt[i].ev) begin
            chk($sformatf("v%0d_pc", i), req_pc, vt[i].epc);
            chk($sformatf("v%0d_mask", i), 32'(req_mask), 32'(vt[i].emask));
            chk($sformatf("v%0d_ex", i), 32'(req_ex), 32'(vt[i].eex));
            chk($sformatf("v%0d_exctype", i), 32'(req_exctype), 32'(vt[i].ecode));
            chk($sformatf("v%0d_req_epoch", i), 32'(req_epoch), 32'(vt[i].eep));
         end
         if (i == 0) begin
            chk("reset_redirect_cnt", redirect_cnt, 32'd0);
            chk("reset_mispred_cnt", mispred_cnt, 32'd0);
            chk("reset_mask", 32'(req_mask), 32'd0);
            chk("reset_exctype", 32'(req_exctype), 32'd0);
         end
         if (i == 16) chk("mispred_cnt_after_full_redirect", mispred_cnt, 32'd3);
         if (i == 18) chk("redirect_cnt_after_eret", redirect_cnt, 32'd4);
      end
      chk("redirect_cnt_table_end", redirect_cnt, 32'd7);

      // Reset in the middle of a stalled, predicted stream.
      clr_inputs();
      req_ready = 1'b0; bpu_valid = 1'b1; bpu_slot = 1'b1; bpu_target = 32'h8000_7000;
      for (int i = 0; i < 3; i++) cycle();
      clr_inputs();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("midreset_valid", 32'(req_valid), 32'd0);
      chk("midreset_epoch", 32'(cur_epoch), 32'd0);
      chk("midreset_redirect_cnt", redirect_cnt, 32'd0);
      n = 0;
      cycle();
      while (!req_valid && n < 10) begin cycle(); n++; end
      chk("midreset_head_appears", 32'(req_valid), 32'd1);
      chk("midreset_head_pc", req_pc, RESET_VEC);
      chk("midreset_head_mask", 32'(req_mask), 32'd3);
      cycle();
      chk("midreset_no_pending", req_pc, 32'hBFC0_0008);
      chk("midreset_no_pending_mask", 32'(req_mask), 32'd3);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         int r;
         clr_inputs();
         r = int'($urandom_range(0, 99));
         eret_valid  = (r < 3);
         flush       = (r >= 3 && r < 6);
         br_redirect = (r >= 6 && r < 10);
         flush_refill = $urandom_range(0, 1) == 1;
         eret_pc   = 32'h8000_0000 | ($urandom & 32'h000F_FFFC) | (($urandom_range(0, 29) == 0) ? 32'd2 : 32'd0);
         br_target = 32'h8000_0000 | ($urandom & 32'h000F_FFFC) | (($urandom_range(0, 29) == 0) ? 32'd1 : 32'd0);
         bpu_valid  = $urandom_range(0, 9) < 3;
         bpu_slot   = 1'($urandom_range(0, 1));
         bpu_target = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
         itlb_refill  = $urandom_range(0, 49) == 0;
         itlb_invalid = $urandom_range(0, 49) == 0;
         req_ready    = $urandom_range(0, 9) < 7;
         reset        = $urandom_range(0, 499) == 0;
         cycle();
         compare_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
